// File: rtl/reg_en_pkg.sv
// Shared constants and decode helpers for the register-enable sequencer,
// the register file and the control unit.
package reg_en_pkg;

    localparam int DEFAULT_NUM_REGS = 3;
    localparam int DEFAULT_DEPTH    = 4;
    localparam int MAX_REGS         = 32;

    // The select code one past the last register means "write nothing".
    function automatic int unsigned sel_none(input int unsigned num_regs);
        return num_regs;
    endfunction

    // Codes at or above num_regs decode to no enable at all.
    function automatic logic [MAX_REGS-1:0] onehot(input int unsigned code,
                                                   input int unsigned num_regs);
        return (code < num_regs) ? (MAX_REGS'(1) << code) : '0;
    endfunction

endpackage

// File: rtl/reg_sel_fifo.sv
// Select-code FIFO: power-of-two depth, wrapping pointers, registered occupancy.
module reg_sel_fifo
    import reg_en_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: storage is left unreset; count gates every read, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/reg_en_sequencer.sv
// Queued one-hot register write-enable sequencer with valid/ready intake and stall.
// Optional sticky illegal-code flag (err/err_clr) when REG_EN_ERR_EN is defined.
module reg_en_sequencer
    import reg_en_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int DEPTH    = DEFAULT_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                req_valid,
    input  logic [$clog2(NUM_REGS+1)-1:0]       req_sel,
    output logic                                req_ready,
    input  logic                                stall,
`ifdef REG_EN_ERR_EN
    output logic                                err,
    input  logic                                err_clr,
`endif
    output logic [NUM_REGS-1:0]                 en,
    output logic                                busy,
    output logic [$clog2(DEPTH+1)-1:0]          count
);

    localparam int SEL_W = $clog2(NUM_REGS+1);
    localparam logic [SEL_W-1:0] SEL_NONE = SEL_W'(sel_none(NUM_REGS));

    logic             accept;
    logic             legal;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [SEL_W-1:0] head;
    logic [MAX_REGS-1:0] dec;

    // When "none" is the largest encodable code, every code is legal.
    if (SEL_NONE == {SEL_W{1'b1}}) begin : g_all_legal
        assign legal = 1'b1;
    end else begin : g_range_check
        assign legal = (req_sel <= SEL_NONE);
    end

    assign req_ready = !full;
    assign busy      = !empty;
    assign accept    = req_valid && req_ready;
    assign push      = accept && legal;
    assign pop       = !stall && !empty;
    assign dec       = onehot(32'(head), NUM_REGS);

    reg_sel_fifo #(.W(SEL_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (req_sel),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) en <= '0;
        else        en <= pop ? dec[NUM_REGS-1:0] : '0;
    end

`ifdef REG_EN_ERR_EN
    // Set has priority over clear so an illegal code is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 err <= 1'b0;
        else if (accept && !legal)  err <= 1'b1;
        else if (err_clr)           err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_reg_en_sequencer.sv
// Directed self-checking bench for reg_en_sequencer (default build and REG_EN_ERR_EN build).
module tb_reg_en_sequencer;

`ifdef REG_EN_ERR_EN
    localparam int NR = 5;
`else
    localparam int NR = 3;
`endif
    localparam int DP = 4;
    localparam int SW = $clog2(NR+1);
    localparam int CW = $clog2(DP+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [SW-1:0] req_sel = '0;
    logic          req_ready;
    logic          stall = 1'b0;
    logic [NR-1:0] en;
    logic          busy;
    logic [CW-1:0] count;
`ifdef REG_EN_ERR_EN
    logic          err;
    logic          err_clr = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_en_sequencer #(.NUM_REGS(NR), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .stall     (stall),
`ifdef REG_EN_ERR_EN
        .err       (err),
        .err_clr   (err_clr),
`endif
        .en        (en),
        .busy      (busy),
        .count     (count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (en !== '0 || count !== '0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset: en=%b count=%0d busy=%b ready=%b, want en=0 count=0 busy=0 ready=1",
                     en, count, busy, req_ready);
        end
`ifdef REG_EN_ERR_EN
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err: err=%b, want 0", err);
        end
`endif
        rst_n = 1'b1;
    endtask

    // Codes 0,1,2 back to back: enables follow one edge after each accept.
    task automatic test_in_order();
        int exp_en  [5] = '{0, 1, 2, 4, 0};
        int exp_cnt [5] = '{1, 1, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            req_valid = (i < 3);
            req_sel   = SW'(i % 3);
            step();
            total++;
            if (en !== NR'(exp_en[i]) || count !== CW'(exp_cnt[i]) || busy !== (exp_cnt[i] != 0)) begin
                bad++;
                $display("FAIL in_order[%0d]: en=%b count=%0d busy=%b, want en=%b count=%0d",
                         i, en, count, busy, NR'(exp_en[i]), exp_cnt[i]);
            end
        end
    endtask

    task automatic test_none();
        req_valid = 1'b1;
        req_sel   = SW'(NR);
        step();
        req_valid = 1'b0;
        total++;
        if (count !== CW'(1) || en !== '0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL none_push: en=%b count=%0d busy=%b, want en=0 count=1 busy=1", en, count, busy);
        end
        step();
        total++;
        if (count !== '0 || en !== '0) begin
            bad++;
            $display("FAIL none_pop: en=%b count=%0d, want en=0 count=0", en, count);
        end
    endtask

    // Fill under stall, hold the fifth code, then drain in order.
    task automatic test_stall_full();
        int codes   [5] = '{0, 1, 2, 0, 1};
        int exp_en  [5] = '{1, 2, 4, 1, 2};
        int exp_cnt [5] = '{3, 3, 2, 1, 0};
        stall     = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_sel = SW'(codes[i]);
            step();
        end
        total++;
        if (count !== CW'(4) || req_ready !== 1'b0 || en !== '0) begin
            bad++;
            $display("FAIL full: count=%0d ready=%b en=%b, want count=4 ready=0 en=0", count, req_ready, en);
        end
        req_sel = SW'(codes[4]);
        step();
        total++;
        if (count !== CW'(4) || en !== '0) begin
            bad++;
            $display("FAIL held: count=%0d en=%b, want count=4 en=0", count, en);
        end
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 1) req_valid = 1'b0;
            total++;
            if (en !== NR'(exp_en[i]) || count !== CW'(exp_cnt[i])) begin
                bad++;
                $display("FAIL drain[%0d]: en=%b count=%0d, want en=%b count=%0d",
                         i, en, count, NR'(exp_en[i]), exp_cnt[i]);
            end
        end
        step();
        total++;
        if (en !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL drain_idle: en=%b busy=%b, want en=0 busy=0", en, busy);
        end
    endtask

    task automatic test_push_pop();
        int codes   [4] = '{1, 2, 0, 0};
        int exp_en  [4] = '{4, 1, 2, 4};
        int exp_cnt [4] = '{2, 2, 1, 0};
        stall     = 1'b1;
        req_valid = 1'b1;
        req_sel   = SW'(2);
        step();
        req_sel   = SW'(0);
        step();
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = (i < 2);
            req_sel   = SW'(codes[i]);
            step();
            total++;
            if (en !== NR'(exp_en[i]) || count !== CW'(exp_cnt[i])) begin
                bad++;
                $display("FAIL push_pop[%0d]: en=%b count=%0d, want en=%b count=%0d",
                         i, en, count, NR'(exp_en[i]), exp_cnt[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        stall     = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_sel = SW'(i % 3);
            step();
        end
        req_valid = 1'b0;
        stall     = 1'b0;
        step();
        total++;
        if (en !== NR'(1) || count !== CW'(3)) begin
            bad++;
            $display("FAIL pre_reset: en=%b count=%0d, want en=001 count=3", en, count);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (en !== '0 || count !== '0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: en=%b count=%0d busy=%b ready=%b, want 0 0 0 1",
                     en, count, busy, req_ready);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (en !== '0 || count !== '0) begin
                bad++;
                $display("FAIL post_reset[%0d]: en=%b count=%0d, want en=0 count=0", i, en, count);
            end
        end
    endtask

`ifdef REG_EN_ERR_EN
    task automatic test_err();
        req_valid = 1'b1;
        req_sel   = SW'(7);
        step();
        total++;
        if (err !== 1'b1 || count !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL err_set: err=%b count=%0d busy=%b, want err=1 count=0 busy=0", err, count, busy);
        end
        err_clr = 1'b1;
        step();
        total++;
        if (err !== 1'b1 || count !== '0) begin
            bad++;
            $display("FAIL err_set_wins: err=%b count=%0d, want err=1 count=0", err, count);
        end
        req_valid = 1'b0;
        step();
        err_clr = 1'b0;
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_clr: err=%b, want 0", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_in_order();
        test_none();
        test_stall_full();
        test_push_pop();
        test_reset_mid();
`ifdef REG_EN_ERR_EN
        test_err();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_en_sequencer.md
# reg_en_sequencer

Parametrised, queued successor to the 2-bit register-enable decoder in the 4-bit microprocessor datapath. It accepts destination-select codes from the control unit through a valid/ready handshake and buffers them in a small FIFO. It then issues one registered one-hot write-enable per code to the register file (Reg_A, Reg_B, Reg_0, … Reg_N-1). A stall input can hold back issue, so the control unit no longer needs to hold D1/D0 stable for the register write.

## Interface
- NUM_REGS, 3, number of enable-able registers (≥2); select code NUM_REGS means "none"
- DEPTH, 4, FIFO depth in codes (power of two, ≥2)
- SEL_W, $clog2(NUM_REGS+1), derived localparam, select code width; not overridable
- CNT_W, $clog2(DEPTH+1), derived localparam, occupancy width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  select code offered
- req_sel  in  SEL_W  destination code: 0..NUM_REGS-1 selects a register; NUM_REGS selects none; above NUM_REGS is illegal
- req_ready  out  1  FIFO can accept; equals !full
- stall  in  1  hold issue this cycle
- en  out  NUM_REGS  registered one-hot write enable, one-cycle pulse
- busy  out  1  FIFO non-empty
- count  out  CNT_W  FIFO occupancy
- err  out  1  sticky illegal-code flag; present only with REG_EN_ERR_EN
- err_clr  in  1  clears err; present only with REG_EN_ERR_EN

## Operation
- Accept: a code is accepted when req_valid && req_ready on a rising edge.
  - A legal code (≤NUM_REGS) is pushed to the FIFO.
  - An illegal code (>NUM_REGS) completes the handshake but is discarded and never queued.
- Issue: on each edge with !stall and !empty, pop the head and load en <= onehot(head).
  - A head equal to NUM_REGS pops and loads en <= 0.
  - With stall=1 or FIFO empty, en <= 0.
- en is at most one-hot and is never high for two consecutive cycles for the same code.
- Push and pop in the same cycle leave count unchanged. FIFO order is preserved.
- Full: req_ready=0. There is no same-cycle pop bypass, so ready stays low during the cycle in which a pop frees space.
- Empty + push: the code is not issued in the accept cycle; there is no input-to-en bypass.
- Pointers wrap modulo DEPTH. count saturates naturally at 0..DEPTH and never over/underflows.

## Timing
- Reset (rst_n low, any time): en=0, count=0, busy=0, req_ready=1, err=0, pointers=0. Queued codes are discarded.
  - Reset takes effect immediately.
  - The first accept happens on the first rising edge with rst_n high.
- Latency: a code accepted at edge k with the FIFO empty and stall=0 at edge k+1 produces en valid in the cycle after edge k+1, for exactly one cycle.
- Throughput: one issue per cycle with stall low; back-to-back codes produce back-to-back en pulses.
- stall is sampled at the edge. en falls to 0 in the cycle after stall rises. Issue resumes at the first edge with stall low.
- req_ready, busy and count are functions of registered state only, with no combinational path from req_valid or stall.

## Configuration
- REG_EN_ERR_EN defined:
  - err and err_clr ports exist.
  - err sets on the edge that accepts an illegal code.
  - err_clr=1 clears err on the next edge.
  - If set and clear occur in the same cycle, set wins.
- REG_EN_ERR_EN undefined: err and err_clr are absent, and illegal codes are silently dropped.
- With the default NUM_REGS=3, SEL_W=2 has no illegal codes, so err stays 0.

## Structure
- Shared package reg_en_pkg holds:
  - the sel_none(NUM_REGS) constant function
  - the onehot decode function
  - the default NUM_REGS/DEPTH constants shared with the register file and the control unit
- Sub-module reg_sel_fifo holds the FIFO: storage array, read/write pointers, count, full and empty.
- The top level holds the legality check, issue logic, en register and err.

## Test plan
- Reset, then push codes 0,1,2 on consecutive cycles with stall=0 -> en = 001, 010, 100 on consecutive cycles, starting two cycles after the first push; busy then falls and count returns to 0.
- Push code 3 (none) with NUM_REGS=3 -> the code pops and en stays 000; count goes 1 -> 0.
- Hold stall=1 and push 5 codes with DEPTH=4 -> count=4 and req_ready=0 after four pushes, and the fifth code is held; release stall -> the four codes issue in order, then the fifth is accepted.
- Simultaneous push and pop at count=2 -> count stays 2 and issue order is preserved.
- Assert rst_n=0 mid-burst with count=3 -> en, count and busy go 0 immediately; after release no stale enable appears.
- With REG_EN_ERR_EN and NUM_REGS=5, push code 7 -> not queued and err=1; assert err_clr together with another illegal push -> err stays 1; err_clr alone -> err=0.
